// File: rtl/ppu_spr_render.sv
// Sprite output stage: eight sprite slots with X down-counters and pattern shifters.
// Resolves sprite priority against the background and keeps a sticky sprite-0 hit flag.
module ppu_spr_render #(
  parameter int NUM_SLOTS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x_idx,
  input  logic [9:0] scanline,
  input  logic       load_en,
  input  logic [2:0] load_slot,
  input  logic [7:0] load_attr,
  input  logic [7:0] load_x,
  input  logic [7:0] load_lo,
  input  logic [7:0] load_hi,
  input  logic       show_bg,
  input  logic       show_spr,
  input  logic       clip_bg_l,
  input  logic       clip_spr_l,
  input  logic [3:0] bg_pixel,
  output logic [4:0] pixel_out,
  output logic       spr0_hit
);

  logic [7:0] attr_q [NUM_SLOTS];
  logic [7:0] xcnt_q [NUM_SLOTS];
  logic [7:0] lo_q   [NUM_SLOTS];
  logic [7:0] hi_q   [NUM_SLOTS];

  logic       active;
  logic       spr_en;
  logic       bg_en;
  logic [1:0] bg_pat;
  logic [1:0] slot_pat;
  logic       found;
  logic [1:0] win_pat;
  logic [1:0] win_pal;
  logic       win_prio;
  logic       s0_opaque;
  logic [4:0] pix_d;
  logic       hit_set;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  assign active = (scanline >= 10'd1) && (scanline <= 10'd240) && (x_idx < 10'd256);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        attr_q[s] <= '0;
        xcnt_q[s] <= '0;
        lo_q[s]   <= '0;
        hi_q[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (load_en && (load_slot == 3'(s))) begin
          attr_q[s] <= load_attr;
          xcnt_q[s] <= load_x;
          // H-flip is applied once at load so the shifter always emits MSB first
          lo_q[s]   <= load_attr[6] ? rev8(load_lo) : load_lo;
          hi_q[s]   <= load_attr[6] ? rev8(load_hi) : load_hi;
        end else if (active) begin
          if (xcnt_q[s] != 8'd0) begin
            xcnt_q[s] <= xcnt_q[s] - 8'd1;
          end else begin
            lo_q[s] <= {lo_q[s][6:0], 1'b0};
            hi_q[s] <= {hi_q[s][6:0], 1'b0};
          end
        end
      end
    end
  end

  always_comb begin
    spr_en    = show_spr && !(clip_spr_l && (x_idx < 10'd8));
    bg_en     = show_bg && !(clip_bg_l && (x_idx < 10'd8));
    bg_pat    = bg_en ? bg_pixel[1:0] : 2'b00;
    slot_pat  = 2'b00;
    found     = 1'b0;
    win_pat   = 2'b00;
    win_pal   = 2'b00;
    win_prio  = 1'b0;
    s0_opaque = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      slot_pat = (xcnt_q[s] == 8'd0) ? {hi_q[s][7], lo_q[s][7]} : 2'b00;
      if (!spr_en) slot_pat = 2'b00;
      if ((slot_pat != 2'b00) && !found) begin
        found    = 1'b1;
        win_pat  = slot_pat;
        win_pal  = attr_q[s][1:0];
        win_prio = attr_q[s][5];
      end
      // sprite 0 may be hidden behind a lower-index slot and still register a hit
      if ((slot_pat != 2'b00) && attr_q[s][2]) s0_opaque = 1'b1;
    end
    if ((win_pat != 2'b00) && (!win_prio || (bg_pat == 2'b00)))
      pix_d = {1'b1, win_pal, win_pat};
    else if (bg_pat != 2'b00)
      pix_d = {1'b0, bg_pixel[3:2], bg_pat};
    else
      pix_d = 5'b0;
    hit_set = active && (x_idx != 10'd255) && s0_opaque && (bg_pat != 2'b00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_out <= 5'b0;
      spr0_hit  <= 1'b0;
    end else begin
      pixel_out <= active ? pix_d : 5'b0;
      if ((scanline == 10'd0) && (x_idx == 10'd0)) spr0_hit <= 1'b0;
      else if (hit_set)                            spr0_hit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ppu_spr_render.sv
// Bench for ppu_spr_render: a positional sprite model feeds a per-dot scoreboard,
// plus directed checks on the pixels each scenario is about.
module tb_ppu_spr_render;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x_idx;
  logic [9:0] scanline;
  logic       load_en;
  logic [2:0] load_slot;
  logic [7:0] load_attr, load_x, load_lo, load_hi;
  logic       show_bg, show_spr, clip_bg_l, clip_spr_l;
  logic [3:0] bg_pixel;
  logic [4:0] pixel_out;
  logic       spr0_hit;

  ppu_spr_render #(.NUM_SLOTS(8)) dut (
    .clk(clk), .reset(reset), .x_idx(x_idx), .scanline(scanline),
    .load_en(load_en), .load_slot(load_slot), .load_attr(load_attr),
    .load_x(load_x), .load_lo(load_lo), .load_hi(load_hi),
    .show_bg(show_bg), .show_spr(show_spr), .clip_bg_l(clip_bg_l),
    .clip_spr_l(clip_spr_l), .bg_pixel(bg_pixel),
    .pixel_out(pixel_out), .spr0_hit(spr0_hit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_attr [8];
  logic [7:0] m_x    [8];
  logic [7:0] m_lo   [8];
  logic [7:0] m_hi   [8];
  logic       exp_hit;
  int         bg_mode;
  logic [3:0] bg_const;
  logic [5:0] sb_q [$];
  logic [4:0] obs_pix [341];
  logic       obs_hit [341];

  task automatic clear_model();
    for (int s = 0; s < 8; s++) begin
      m_attr[s] = '0; m_x[s] = '0; m_lo[s] = '0; m_hi[s] = '0;
    end
  endtask

  task automatic set_slot(input int s, input logic [7:0] a, input logic [7:0] xp,
                          input logic [7:0] lo, input logic [7:0] hi);
    m_attr[s] = a; m_x[s] = xp; m_lo[s] = lo; m_hi[s] = hi;
  endtask

  function automatic logic [1:0] model_pat(input int s, input int x);
    int i;
    logic l, h;
    if (x < int'(m_x[s]) || x >= int'(m_x[s]) + 8) return 2'b00;
    i = x - int'(m_x[s]);
    l = m_attr[s][6] ? m_lo[s][i] : m_lo[s][7-i];
    h = m_attr[s][6] ? m_hi[s][i] : m_hi[s][7-i];
    return {h, l};
  endfunction

  // Every slot is written twice (garbage first) so the last-write-wins path is exercised.
  task automatic load_slots();
    scanline = 10'd250;
    for (int pass = 0; pass < 2; pass++) begin
      for (int s = 0; s < 8; s++) begin
        x_idx     = 10'(256 + s);
        load_en   = 1'b1;
        load_slot = 3'(s);
        load_attr = pass == 0 ? ~m_attr[s] : m_attr[s];
        load_x    = pass == 0 ? ~m_x[s]    : m_x[s];
        load_lo   = pass == 0 ? ~m_lo[s]   : m_lo[s];
        load_hi   = pass == 0 ? ~m_hi[s]   : m_hi[s];
        @(posedge clk); #1;
      end
    end
    load_en = 1'b0;
  endtask

  task automatic run_line(input int sl, input int rst_at);
    logic [5:0] exp;
    logic [4:0] ep;
    logic [1:0] sp, bp, wp, wpal;
    logic       wprio, s0;
    bit         act;
    for (int x = 0; x < 341; x++) begin
      if (x == rst_at) begin
        reset = 1'b1;
        #1;
        n_checks++;
        if (pixel_out !== 5'b0) $display("FAIL rst_mid_pix got %b want 00000", pixel_out);
        else n_pass++;
        n_checks++;
        if (spr0_hit !== 1'b0) $display("FAIL rst_mid_hit got %b want 0", spr0_hit);
        else n_pass++;
        reset = 1'b0;
        #1;
        clear_model();
        exp_hit = 1'b0;
      end
      x_idx    = 10'(x);
      scanline = 10'(sl);
      bg_pixel = bg_mode == 1 ? 4'(x) : bg_const;
      act = (sl >= 1) && (sl <= 240) && (x < 256);
      ep = 5'b0;
      if (act) begin
        bp = (show_bg && !(clip_bg_l && x < 8)) ? bg_pixel[1:0] : 2'b00;
        wp = 2'b00; wpal = 2'b00; wprio = 1'b0; s0 = 1'b0;
        for (int s = 7; s >= 0; s--) begin
          sp = (show_spr && !(clip_spr_l && x < 8)) ? model_pat(s, x) : 2'b00;
          if (sp != 2'b00) begin
            wp = sp; wpal = m_attr[s][1:0]; wprio = m_attr[s][5];
            if (m_attr[s][2]) s0 = 1'b1;
          end
        end
        if (wp != 0 && (!wprio || bp == 0)) ep = {1'b1, wpal, wp};
        else if (bp != 0)                   ep = {1'b0, bg_pixel[3:2], bp};
        if (s0 && bp != 0 && x != 255) exp_hit = 1'b1;
      end else if (sl == 0 && x == 0) begin
        exp_hit = 1'b0;
      end
      sb_q.push_back({exp_hit, ep});
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      obs_pix[x] = pixel_out;
      obs_hit[x] = spr0_hit;
      n_checks++;
      if (pixel_out !== exp[4:0])
        $display("FAIL sb_pix sl=%0d x=%0d got %b want %b", sl, x, pixel_out, exp[4:0]);
      else n_pass++;
      n_checks++;
      if (spr0_hit !== exp[5])
        $display("FAIL sb_hit sl=%0d x=%0d got %b want %b", sl, x, spr0_hit, exp[5]);
      else n_pass++;
    end
  endtask

  task automatic chk_pix(input string nm, input int x, input logic [4:0] want);
    n_checks++;
    if (obs_pix[x] !== want) $display("FAIL %s x=%0d got %b want %b", nm, x, obs_pix[x], want);
    else n_pass++;
  endtask

  task automatic chk_hit(input string nm, input int x, input logic want);
    n_checks++;
    if (obs_hit[x] !== want) $display("FAIL %s x=%0d got %b want %b", nm, x, obs_hit[x], want);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (pixel_out !== 5'b0) $display("FAIL reset_pix got %b want 00000", pixel_out);
    else n_pass++;
    n_checks++;
    if (spr0_hit !== 1'b0) $display("FAIL reset_hit got %b want 0", spr0_hit);
    else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
    clear_model();
    exp_hit = 1'b0;
    bg_mode = 1;
    run_line(5, -1);
    chk_pix("empty_bg", 5, 5'b00101);
  endtask

  task automatic test_single();
    clear_model();
    set_slot(0, 8'h00, 8'd10, 8'h80, 8'h00);
    bg_mode = 0; bg_const = 4'h0;
    load_slots();
    run_line(1, -1);
    chk_pix("single_on", 10, 5'b10001);
    chk_pix("single_pre", 9, 5'b00000);
    chk_pix("single_post", 11, 5'b00000);
  endtask

  task automatic test_priority();
    clear_model();
    set_slot(0, 8'h21, 8'd20, 8'h80, 8'h80);
    bg_mode = 0; bg_const = 4'b0110;
    load_slots();
    run_line(2, -1);
    chk_pix("prio_behind", 20, 5'b00110);
    bg_const = 4'h0;
    load_slots();
    run_line(3, -1);
    chk_pix("prio_front", 20, 5'b10111);
  endtask

  task automatic test_overlap();
    clear_model();
    set_slot(0, 8'h20, 8'd30, 8'h80, 8'h80);
    set_slot(1, 8'h03, 8'd30, 8'hFF, 8'hFF);
    bg_mode = 0; bg_const = 4'b1101;
    load_slots();
    run_line(4, -1);
    chk_pix("overlap_bg", 30, 5'b01101);
    chk_pix("overlap_s1", 31, 5'b11111);
  endtask

  task automatic test_spr0_hit();
    clear_model();
    set_slot(3, 8'h04, 8'd100, 8'h80, 8'h00);
    bg_mode = 0; bg_const = 4'b0001;
    load_slots();
    run_line(6, -1);
    chk_hit("hit_before", 99, 1'b0);
    chk_hit("hit_at", 100, 1'b1);
    chk_hit("hit_hold", 300, 1'b1);
    clear_model();
    load_slots();
    run_line(7, -1);
    chk_hit("hit_sticky", 0, 1'b1);
    run_line(0, -1);
    chk_hit("hit_clear", 0, 1'b0);
  endtask

  task automatic test_hit_edges();
    clear_model();
    set_slot(0, 8'h04, 8'd255, 8'h80, 8'h00);
    bg_mode = 0; bg_const = 4'b0001;
    load_slots();
    run_line(8, -1);
    chk_pix("x255_pix", 255, 5'b10001);
    chk_hit("x255_nohit", 255, 1'b0);
    clear_model();
    set_slot(0, 8'h04, 8'd3, 8'h80, 8'h00);
    clip_spr_l = 1'b1;
    load_slots();
    run_line(9, -1);
    chk_pix("clip_pix", 3, 5'b00001);
    chk_hit("clip_nohit", 3, 1'b0);
    clip_spr_l = 1'b0;
    load_slots();
    run_line(10, -1);
    chk_pix("noclip_pix", 3, 5'b10001);
    chk_hit("noclip_hit", 3, 1'b1);
    run_line(0, -1);
  endtask

  task automatic test_flip_reset();
    clear_model();
    set_slot(0, 8'h44, 8'd50, 8'h01, 8'h00);
    bg_mode = 0; bg_const = 4'b1010;
    load_slots();
    run_line(11, 52);
    chk_pix("flip_pix", 50, 5'b10001);
    chk_hit("flip_hit", 50, 1'b1);
    chk_pix("after_rst", 52, 5'b01010);
    chk_hit("after_rst_hit", 60, 1'b0);
  endtask

  task automatic test_random();
    bg_mode = 1;
    for (int l = 0; l < 4; l++) begin
      clear_model();
      for (int s = 0; s < 8; s++)
        set_slot(s, 8'($urandom), 8'($urandom_range(0, 255)), 8'($urandom), 8'($urandom));
      show_bg    = 1'($urandom);
      show_spr   = (l != 3);
      clip_bg_l  = 1'($urandom);
      clip_spr_l = 1'($urandom);
      load_slots();
      run_line(100 + l, -1);
    end
    show_bg = 1'b1; show_spr = 1'b1; clip_bg_l = 1'b0; clip_spr_l = 1'b0;
    run_line(0, -1);
  endtask

  initial begin
    reset = 1'b0; x_idx = '0; scanline = 10'd250; load_en = 1'b0; load_slot = '0;
    load_attr = '0; load_x = '0; load_lo = '0; load_hi = '0;
    show_bg = 1'b1; show_spr = 1'b1; clip_bg_l = 1'b0; clip_spr_l = 1'b0;
    bg_pixel = '0; bg_mode = 0; bg_const = '0; exp_hit = 1'b0;
    #2;
    test_reset();
    test_single();
    test_priority();
    test_overlap();
    test_spr0_hit();
    test_hit_edges();
    test_flip_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
